prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Downstream stage of the array multiplier: consumes each PROD_W-bit product, adds it into an ACC_W-bit running sum and counts the accepted products.
- On request, snapshots the sum and streams it out LSB-first as 8-bit bytes with a valid/ready handshake, so it fits the 8-bit uo_out path.
- Accumulation continues while a dump is being streamed out.

Parameters:
- PROD_W, 8, multiplier product width.
- ACC_W, 16, accumulator width; must be a multiple of 8 and greater than PROD_W.
- CNT_W, 4, width of the product counter; the counter saturates.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  design enable; low freezes all registers
- prod_i  in  PROD_W  product from the multiplier, zero-extended
- prod_valid_i  in  1  prod_i is valid this cycle
- clear_i  in  1  zero acc, count and ovf
- dump_i  in  1  request a readout of acc
- out_ready_i  in  1  consumer accepts out_data_o
- out_data_o  out  8  readout byte
- out_valid_o  out  1  out_data_o is valid
- out_last_o  out  1  current byte is the final byte
- acc_o  out  ACC_W  live accumulator value
- count_o  out  CNT_W  number of accepted products, saturating at 2^CNT_W-1
- ovf_o  out  1  sticky overflow flag
- busy_o  out  1  dump in progress

Behaviour:
- Clock and reset: single clock domain, clk rising edge. rst_n is synchronous and active-low.
- Reset values: all registers 0, state ACC, out_valid_o=0, out_last_o=0, busy_o=0. rst_n wins over ena and over every other input.
- ena=0: every register holds its value; outputs stay stable.
- Accumulate: if prod_valid_i=1, then next cycle acc = acc + zext(prod_i) mod 2^ACC_W and count = min(count+1, max).
- Overflow: a carry out of the MSB sets ovf=1, which stays set until clear_i or reset.
- Clear: clear_i=1 zeroes acc, count and ovf next cycle.
- Clear and product in the same cycle: acc=zext(prod_i), count=1, ovf=0. Clear has priority, then the add is applied.
- FSM states: ACC, DUMP (beat index b, 0..ACC_W/8-1).
- ACC -> DUMP:
  - Triggered when dump_i=1.
  - The shadow register captures acc as it was before that cycle's add or clear.
  - Next cycle: out_valid_o=1, out_data_o=shadow[7:0], busy_o=1.
- DUMP handshake:
  - A beat transfers when out_valid_o and out_ready_i are both 1.
  - Until the transfer, out_data_o and out_last_o stay stable.
  - After the transfer, b increments and the next byte is presented the following cycle.
  - out_last_o=1 exactly on beat ACC_W/8-1.
  - The transfer of the last beat returns the FSM to ACC with out_valid_o=0 next cycle. There are no bubbles between beats.
- dump_i while in DUMP: ignored, not queued.
- Accumulation and clear during DUMP: both keep operating on acc. The shadow register is unaffected.
- Reset mid-dump: the stream is aborted and out_valid_o=0 next cycle.
- Latency: acc_o reflects a product 1 cycle after it is presented. The first dump byte appears 1 cycle after dump_i.

Optional Feature:
- Macro: PROD_ACC_SATURATE_EN.
- When defined: the add saturates at 2^ACC_W-1, and ovf is set when saturation occurs.
- When undefined: the add wraps modulo 2^ACC_W, and ovf is set on carry out.
- All other behaviour is identical in both builds.

Decomposition:
- Package prod_acc_pkg holds:
  - default widths (PROD_W, ACC_W, CNT_W);
  - the state enum {ST_ACC, ST_DUMP};
  - the constant NBEATS = ACC_W/8.
- Sub-module acc_dump_serializer holds the shadow register, beat counter and valid/ready/last logic.
- Top level: accumulator datapath, counter, ovf, and the serializer instance.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with prod_valid_i=1, prod_i=0xFF -> acc_o=0x0000, count_o=0, ovf_o=0, out_valid_o=0.
2. Accumulate: feed 0xE1, 0xE1, 0x10 on consecutive cycles -> acc_o=0x01D2, count_o=3, ovf_o=0.
3. Dump with backpressure: with acc=0x01D2, pulse dump_i and hold out_ready_i=0 for 3 cycles, then set it to 1.
   - out_data_o=0xD2, out_last_o=0, stable through the stall.
   - Then 0x01 with out_last_o=1.
   - Then out_valid_o=0, busy_o=0.
4. Dump and product in the same cycle: with acc=0x01D2, dump_i=1 and prod_i=0x05 valid together.
   - Streamed bytes are 0xD2, 0x01.
   - acc_o=0x01D7.
   - A second dump_i mid-stream is ignored.
5. Overflow: 257 products of 0xFF (acc=0xFFFF, count_o=15), then 0x02.
   - Default build: acc_o=0x0001, ovf_o=1.
   - With PROD_ACC_SATURATE_EN: acc_o=0xFFFF, ovf_o=1.
6. Clear and product in the same cycle: with acc=0x1234 and ovf=1, clear_i=1 and prod_i=0x07 valid together -> acc_o=0x0007, count_o=1, ovf_o=0. Also toggle ena=0 for 2 cycles -> no register changes.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared widths, FSM state type and helpers for the product accumulator.
// Build option: PROD_ACC_SATURATE_EN (consumed by prod_accumulator).
package prod_acc_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 4;
    localparam int NBEATS     = DEF_ACC_W / 8;

    typedef enum logic {
        ST_ACC,
        ST_DUMP
    } state_t;

    // Beats-remaining counter width; never zero even for a single-beat sum.
    function automatic int beat_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/prod_acc_if.sv
// Byte-wide readout stream of the accumulator (valid/ready/last).
interface prod_acc_if;

    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_last_o;
    logic       out_ready_i;

    modport master (
        output out_data_o,
        output out_valid_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        input  out_last_o,
        output out_ready_i
    );

endinterface

// File: rtl/acc_dump_serializer.sv
// Snapshots the accumulator on a dump request and streams it out LSB-first.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_ACC  | idle; dump_i captures acc into the shadow register
//   ST_DUMP | presenting shadow[7:0]; beats_left counts down to the last
module acc_dump_serializer
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             dump_i,
    input  logic [ACC_W-1:0] acc,
    prod_acc_if.master       stream,
    output logic             busy_o
);

    localparam int NB     = ACC_W / 8;
    localparam int BEAT_W = beat_w(NB);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    shadow_q, shadow_d;
    logic [BEAT_W-1:0]   beats_left_q, beats_left_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACC;
            shadow_q     <= '0;
            beats_left_q <= '0;
        end else if (ena) begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_ACC: begin
                if (dump_i) begin
                    state_d      = ST_DUMP;
                    shadow_d     = acc;
                    beats_left_d = BEAT_W'(NB - 1);
                end
            end
            ST_DUMP: begin
                // Shifting the shadow keeps the output mux to a fixed byte lane.
                if (stream.out_ready_i) begin
                    if (beats_left_q == '0) begin
                        state_d = ST_ACC;
                    end else begin
                        shadow_d     = shadow_q >> 8;
                        beats_left_d = beats_left_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    assign stream.out_valid_o = (state_q == ST_DUMP);
    assign stream.out_data_o  = shadow_q[7:0];
    assign stream.out_last_o  = (state_q == ST_DUMP) && (beats_left_q == '0);
    assign busy_o             = (state_q == ST_DUMP);

endmodule

// File: rtl/prod_accumulator.sv
// Running sum and saturating count of multiplier products, with byte readout.
// Build option: PROD_ACC_SATURATE_EN makes the add saturate instead of wrap.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    input  logic              clear_i,
    input  logic              dump_i,
    prod_acc_if.master        stream,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o,
    output logic              busy_o
);

    logic [ACC_W-1:0] acc_q, acc_d, base_acc;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic             ovf_q, ovf_d, carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (ena) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Clear is folded in first so a same-cycle product lands on a zero base.
    always_comb begin
        base_acc = clear_i ? '0 : acc_q;
        base_cnt = clear_i ? '0 : cnt_q;
        sum      = {1'b0, base_acc} + (ACC_W + 1)'(prod_i);
        carry    = prod_valid_i && sum[ACC_W];
        acc_d    = base_acc;
        cnt_d    = base_cnt;
        if (prod_valid_i) begin
`ifdef PROD_ACC_SATURATE_EN
            acc_d = carry ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (base_cnt != '1) begin
                cnt_d = base_cnt + 1'b1;
            end
        end
        ovf_d = (clear_i ? 1'b0 : ovf_q) | carry;
    end

    acc_dump_serializer #(
        .ACC_W (ACC_W)
    ) u_serializer (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .dump_i (dump_i),
        .acc    (acc_q),
        .stream (stream),
        .busy_o (busy_o)
    );

    assign acc_o   = acc_q;
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: directed scenarios plus random
// traffic against a queue-based reference model of sum, count and readout.
module tb_prod_accumulator;

    localparam int NB      = 2;
    localparam int ACC_MAX = 65535;
    localparam int CNT_MAX = 15;
`ifdef PROD_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  prod_i = '0;
    logic        prod_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        dump_i = 1'b0;
    logic [15:0] acc_o;
    logic [3:0]  count_o;
    logic        ovf_o;
    logic        busy_o;

    prod_acc_if sif();

    prod_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .clear_i      (clear_i),
        .dump_i       (dump_i),
        .stream       (sif),
        .acc_o        (acc_o),
        .count_o      (count_o),
        .ovf_o        (ovf_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         m_acc = 0;
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_q[$];

    // Drive one cycle of inputs, advance the reference model, and settle.
    task automatic step(input logic v, input logic [7:0] p, input logic clr,
                        input logic dmp, input logic rdy,
                        input logic en = 1'b1, input logic rst = 1'b1);
        bit pre_busy;
        int s;
        prod_valid_i    = v;
        prod_i          = p;
        clear_i         = clr;
        dump_i          = dmp;
        sif.out_ready_i = rdy;
        ena             = en;
        rst_n           = rst;
        if (!rst) begin
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_q.delete();
        end else if (en) begin
            pre_busy = (m_q.size() != 0);
            if (pre_busy && rdy) void'(m_q.pop_front());
            if (!pre_busy && dmp)
                for (int i = 0; i < NB; i++) m_q.push_back(8'((m_acc >> (8 * i)) & 255));
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end
            if (v) begin
                s = m_acc + int'(p);
                if (s > ACC_MAX) begin
                    m_ovf = 1'b1;
                    m_acc = SAT ? ACC_MAX : s - (ACC_MAX + 1);
                end else begin
                    m_acc = s;
                end
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (acc_o !== 16'h0000) begin failures++; $display("FAIL reset_acc got=%h exp=0000", acc_o); end
        checks++;
        if (count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++;
        if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid_busy got=%b%b exp=00", sif.out_valid_o, busy_o);
        end
    endtask

    task automatic test_accumulate();
        step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_o !== 16'h00E1) begin failures++; $display("FAIL acc_latency got=%h exp=00e1", acc_o); end
        step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_o !== 16'h01D2 || acc_o !== 16'(m_acc)) begin
            failures++; $display("FAIL accum_acc got=%h exp=01d2", acc_o);
        end
        checks++;
        if (count_o !== 4'd3) begin failures++; $display("FAIL accum_count got=%0d exp=3", count_o); end
        checks++;
        if (ovf_o !== 1'b0) begin failures++; $display("FAIL accum_ovf got=%b exp=0", ovf_o); end
    endtask

    task automatic test_dump_backpressure();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== 8'hD2 || sif.out_last_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL dump_stall%0d got v=%b d=%h l=%b b=%b exp v=1 d=d2 l=0 b=1",
                         i, sif.out_valid_o, sif.out_data_o, sif.out_last_o, busy_o);
            end
            if (i < 2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== 8'h01 || sif.out_last_o !== 1'b1) begin
            failures++;
            $display("FAIL dump_beat1 got v=%b d=%h l=%b exp v=1 d=01 l=1",
                     sif.out_valid_o, sif.out_data_o, sif.out_last_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL dump_end got v=%b b=%b exp v=0 b=0", sif.out_valid_o, busy_o);
        end
    endtask

    task automatic test_dump_with_product();
        step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        checks++;
        if (acc_o !== 16'h01D7) begin failures++; $display("FAIL dumpprod_acc got=%h exp=01d7", acc_o); end
        checks++;
        if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== 8'hD2) begin
            failures++; $display("FAIL dumpprod_b0 got v=%b d=%h exp v=1 d=d2", sif.out_valid_o, sif.out_data_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (sif.out_data_o !== 8'h01 || sif.out_last_o !== 1'b1) begin
            failures++; $display("FAIL dumpprod_b1 got d=%h l=%b exp d=01 l=1", sif.out_data_o, sif.out_last_o);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL dumpprod_ignored got v=%b b=%b exp v=0 b=0", sif.out_valid_o, busy_o);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 257; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_o !== 16'hFFFF || count_o !== 4'd15 || ovf_o !== 1'b0) begin
            failures++; $display("FAIL ovf_full got acc=%h cnt=%0d ovf=%b exp acc=ffff cnt=15 ovf=0", acc_o, count_o, ovf_o);
        end
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_o !== (SAT ? 16'hFFFF : 16'h0001) || ovf_o !== 1'b1) begin
            failures++; $display("FAIL ovf_add got acc=%h ovf=%b exp acc=%h ovf=1", acc_o, ovf_o, SAT ? 16'hFFFF : 16'h0001);
        end
    endtask

    task automatic test_clear_with_product();
        int d;
        while (m_acc < 'h1234) begin
            d = 'h1234 - m_acc;
            step(1'b1, 8'((d > 255) ? 255 : d), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (acc_o !== (SAT ? 16'hFFFF : 16'h1234) || ovf_o !== 1'b1 || count_o !== 4'd15 || sif.out_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL ena_hold%0d got acc=%h ovf=%b cnt=%0d v=%b", i, acc_o, ovf_o, count_o, sif.out_valid_o);
            end
        end
        step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        checks++;
        if (acc_o !== 16'h0007 || count_o !== 4'd1 || ovf_o !== 1'b0) begin
            failures++; $display("FAIL clear_prod got acc=%h cnt=%0d ovf=%b exp acc=0007 cnt=1 ovf=0", acc_o, count_o, ovf_o);
        end
    endtask

    task automatic test_reset_mid_dump();
        step(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (sif.out_valid_o !== 1'b0 || busy_o !== 1'b0 || acc_o !== 16'h0000) begin
            failures++; $display("FAIL reset_mid_dump got v=%b b=%b acc=%h exp v=0 b=0 acc=0000", sif.out_valid_o, busy_o, acc_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 9) != 0));
            checks++;
            if (acc_o !== 16'(m_acc) || count_o !== 4'(m_cnt) || ovf_o !== m_ovf) begin
                failures++;
                $display("FAIL rand_state@%0d got acc=%h cnt=%0d ovf=%b exp acc=%h cnt=%0d ovf=%b",
                         n, acc_o, count_o, ovf_o, 16'(m_acc), m_cnt, m_ovf);
            end
            checks++;
            if (sif.out_valid_o !== (m_q.size() != 0) || busy_o !== (m_q.size() != 0)) begin
                failures++;
                $display("FAIL rand_valid@%0d got v=%b b=%b exp %b", n, sif.out_valid_o, busy_o, m_q.size() != 0);
            end else if (m_q.size() != 0) begin
                checks++;
                if (sif.out_data_o !== m_q[0] || sif.out_last_o !== (m_q.size() == 1)) begin
                    failures++;
                    $display("FAIL rand_beat@%0d got d=%h l=%b exp d=%h l=%b",
                             n, sif.out_data_o, sif.out_last_o, m_q[0], m_q.size() == 1);
                end
            end
        end
    endtask

    initial begin
        sif.out_ready_i = 1'b0;
        test_reset();
        test_accumulate();
        test_dump_backpressure();
        test_dump_with_product();
        test_overflow();
        test_clear_with_product();
        test_reset_mid_dump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
